// File: rtl/wshb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave, grant held for a full CYC tenure.
// Optional slave watchdog enabled by defining WSHB_ARB_TIMEOUT_EN.
module wshb_arbiter #(
   parameter int NUM_M   = 4,
   parameter int ADR_W   = 32,
   parameter int DAT_W   = 32,
   parameter int SEL_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_M-1:0]       m_cyc_i,
   input  logic [NUM_M-1:0]       m_stb_i,
   input  logic [NUM_M-1:0]       m_we_i,
   input  logic [NUM_M*ADR_W-1:0] m_adr_i,
   input  logic [NUM_M*SEL_W-1:0] m_sel_i,
   input  logic [NUM_M*DAT_W-1:0] m_dat_i,
   output logic [DAT_W-1:0]       m_dat_o,
   output logic [NUM_M-1:0]       m_ack_o,
   output logic [NUM_M-1:0]       m_err_o,
   output logic [NUM_M-1:0]       m_rty_o,
   output logic                   s_cyc_o,
   output logic                   s_stb_o,
   output logic                   s_we_o,
   output logic [ADR_W-1:0]       s_adr_o,
   output logic [SEL_W-1:0]       s_sel_o,
   output logic [DAT_W-1:0]       s_dat_o,
   input  logic [DAT_W-1:0]       s_dat_i,
   input  logic                   s_ack_i,
   input  logic                   s_err_i,
   input  logic                   s_rty_i,
   output logic [NUM_M-1:0]       gnt_o
);

   localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_reg, state_next;
   logic [NUM_M-1:0] gnt_reg, gnt_next;
   logic [IDX_W-1:0] last_reg, last_next;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] cand_idx;
   logic             sel_found;
   logic             timeout_hit;

   logic [ADR_W-1:0] adr_masked [NUM_M];
   logic [SEL_W-1:0] sel_masked [NUM_M];
   logic [DAT_W-1:0] dat_masked [NUM_M];

   // Round-robin search starting just after the last granted master.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = last_reg;
      cand_idx  = '0;
      for (int i = 1; i <= NUM_M; i++) begin
         cand_idx = IDX_W'((int'(last_reg) + i) % NUM_M);
         if (!sel_found && m_cyc_i[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (sel_found) begin
               state_next = GRANT;
               gnt_next   = {{(NUM_M-1){1'b0}}, 1'b1} << sel_idx;
               last_next  = sel_idx;
            end
         end
         GRANT: begin
            if (!m_cyc_i[last_reg]) begin
               state_next = IDLE;
               gnt_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         gnt_reg   <= '0;
         last_reg  <= IDX_W'(NUM_M - 1);
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         last_reg  <= last_next;
      end
   end

`ifdef WSHB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   logic [CNT_W-1:0] wd_cnt_reg;

   assign timeout_hit = (state_reg == GRANT) && (wd_cnt_reg == CNT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (!rst || state_reg != GRANT || timeout_hit || s_ack_i || s_err_i || s_rty_i) begin
         wd_cnt_reg <= '0;
      end else if (s_stb_o) begin
         wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Every field is AND-gated by its grant bit, so the slave sees all zeros while idle.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_M; gi++) begin : g_mask
         assign adr_masked[gi] = m_adr_i[gi*ADR_W +: ADR_W] & {ADR_W{gnt_reg[gi]}};
         assign sel_masked[gi] = m_sel_i[gi*SEL_W +: SEL_W] & {SEL_W{gnt_reg[gi]}};
         assign dat_masked[gi] = m_dat_i[gi*DAT_W +: DAT_W] & {DAT_W{gnt_reg[gi]}};
      end
   endgenerate

   always_comb begin
      s_adr_o = '0;
      s_sel_o = '0;
      s_dat_o = '0;
      for (int k = 0; k < NUM_M; k++) begin
         s_adr_o = s_adr_o | adr_masked[k];
         s_sel_o = s_sel_o | sel_masked[k];
         s_dat_o = s_dat_o | dat_masked[k];
      end
   end

   assign s_cyc_o = |(m_cyc_i & gnt_reg);
   assign s_stb_o = |(m_stb_i & gnt_reg);
   assign s_we_o  = |(m_we_i & gnt_reg);

   assign m_ack_o = gnt_reg & {NUM_M{s_ack_i}};
   assign m_err_o = gnt_reg & {NUM_M{s_err_i | timeout_hit}};
   assign m_rty_o = gnt_reg & {NUM_M{s_rty_i}};
   assign m_dat_o = s_dat_i;
   assign gnt_o   = gnt_reg;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Testbench for wshb_arbiter: vector table, directed corner sequences and a random run
// checked every cycle against a tenure-level reference model.
module tb_wshb_arbiter;

   localparam int NUM_M   = 4;
   localparam int ADR_W   = 32;
   localparam int DAT_W   = 32;
   localparam int SEL_W   = 4;
   localparam int TIMEOUT = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NUM_M-1:0]       m_cyc, m_stb, m_we;
   logic [NUM_M*ADR_W-1:0] m_adr;
   logic [NUM_M*SEL_W-1:0] m_sel;
   logic [NUM_M*DAT_W-1:0] m_dat;
   logic [DAT_W-1:0]       m_dat_o;
   logic [NUM_M-1:0]       m_ack_o, m_err_o, m_rty_o;
   logic                   s_cyc_o, s_stb_o, s_we_o;
   logic [ADR_W-1:0]       s_adr_o;
   logic [SEL_W-1:0]       s_sel_o;
   logic [DAT_W-1:0]       s_dat_o;
   logic [DAT_W-1:0]       s_dat_i;
   logic                   s_ack, s_err, s_rty;
   logic [NUM_M-1:0]       gnt_o;

   always #5 clk = ~clk;

   wshb_arbiter #(
      .NUM_M(NUM_M), .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_sel_i(m_sel), .m_dat_i(m_dat),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
      .gnt_o(gnt_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the bus (-1 = nobody), who owned it last, watchdog wait count.
   int gm, last_g, wcnt;
   bit model_on = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NUM_M-1:0] onehot(input int g);
      logic [NUM_M-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   task automatic model_check();
      logic [NUM_M-1:0] eg, eack, eerr, erty;
      logic             ecyc, estb, ewe, to_hit;
      logic [ADR_W-1:0] eadr;
      logic [SEL_W-1:0] esel;
      logic [DAT_W-1:0] edat;
      eg = onehot(gm);
      ecyc = 0; estb = 0; ewe = 0; eadr = '0; esel = '0; edat = '0;
      if (gm >= 0) begin
         ecyc = m_cyc[gm];
         estb = m_stb[gm];
         ewe  = m_we[gm];
         eadr = m_adr[gm*ADR_W +: ADR_W];
         esel = m_sel[gm*SEL_W +: SEL_W];
         edat = m_dat[gm*DAT_W +: DAT_W];
      end
`ifdef WSHB_ARB_TIMEOUT_EN
      to_hit = (gm >= 0) && (wcnt == TIMEOUT);
`else
      to_hit = 1'b0;
`endif
      eack = s_ack ? eg : '0;
      eerr = (s_err || to_hit) ? eg : '0;
      erty = s_rty ? eg : '0;
      check("model_gnt", 64'(gnt_o), 64'(eg));
      check("model_resp", 64'({m_ack_o, m_err_o, m_rty_o}), 64'({eack, eerr, erty}));
      check("model_slave_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o}),
            64'({ecyc, estb, ewe, esel, eadr}));
      check("model_s_dat", 64'(s_dat_o), 64'(edat));
      check("model_m_dat", 64'(m_dat_o), 64'(s_dat_i));
   endtask

   task automatic model_update();
      if (!rst) begin
         gm = -1; last_g = NUM_M - 1; wcnt = 0;
      end else if (gm < 0) begin
         wcnt = 0;
         for (int i = 1; i <= NUM_M; i++) begin
            int k;
            k = (last_g + i) % NUM_M;
            if (gm < 0 && m_cyc[k]) begin
               gm = k;
               last_g = k;
            end
         end
      end else begin
         if (wcnt == TIMEOUT || s_ack || s_err || s_rty) wcnt = 0;
         else if (m_stb[gm]) wcnt++;
         if (!m_cyc[gm]) gm = -1;
      end
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic edge_step();
      if (model_on) model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic tick();
      settle();
      edge_step();
   endtask

   task automatic clear_inputs();
      m_cyc = '0; m_stb = '0; m_we = '0;
      s_ack = 0; s_err = 0; s_rty = 0;
   endtask

   task automatic do_reset();
      rst = 0;
      clear_inputs();
      tick();
      rst = 1;
   endtask

   typedef struct {
      logic             rst;
      logic [NUM_M-1:0] cyc;
      logic [NUM_M-1:0] stb;
      logic             ack;
      logic [NUM_M-1:0] e_gnt;
      logic             e_cyc;
      logic [ADR_W-1:0] e_adr;
      logic [NUM_M-1:0] e_ack;
   } vec_t;

   vec_t tbl [9];

   initial begin
      // Reset hold, then a single read by master 2 with a two-cycle slave wait.
      tbl[0] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 32'h0,  4'h0};
      tbl[1] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 32'h0,  4'h0};
      tbl[2] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 32'h0,  4'h0};
      tbl[3] = '{1'b1, 4'h4, 4'h4, 1'b0, 4'h0, 1'b0, 32'h0,  4'h0};
      tbl[4] = '{1'b1, 4'h4, 4'h4, 1'b0, 4'h4, 1'b1, 32'h40, 4'h0};
      tbl[5] = '{1'b1, 4'h4, 4'h4, 1'b0, 4'h4, 1'b1, 32'h40, 4'h0};
      tbl[6] = '{1'b1, 4'h4, 4'h4, 1'b1, 4'h4, 1'b1, 32'h40, 4'h4};
      tbl[7] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h4, 1'b0, 32'h40, 4'h0};
      tbl[8] = '{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 32'h0,  4'h0};

      gm = -1; last_g = NUM_M - 1; wcnt = 0;
      clear_inputs();
      for (int k = 0; k < NUM_M; k++) begin
         m_adr[k*ADR_W +: ADR_W] = 32'(k * 32'h20);
         m_sel[k*SEL_W +: SEL_W] = 4'hF;
         m_dat[k*DAT_W +: DAT_W] = 32'h1111_0000 + 32'(k);
      end
      s_dat_i = 32'hDEAD_BEEF;
      rst = 0;
      m_cyc = 4'hF;
      @(posedge clk);
      #1;
      tick();
      model_on = 1'b1;

      for (int i = 0; i < 9; i++) begin
         rst = tbl[i].rst; m_cyc = tbl[i].cyc; m_stb = tbl[i].stb; s_ack = tbl[i].ack;
         settle();
         check("tbl_gnt", 64'(gnt_o), 64'(tbl[i].e_gnt));
         check("tbl_s_cyc", 64'(s_cyc_o), 64'(tbl[i].e_cyc));
         check("tbl_s_adr", 64'(s_adr_o), 64'(tbl[i].e_adr));
         check("tbl_ack", 64'(m_ack_o), 64'(tbl[i].e_ack));
         check("tbl_m_dat", 64'(m_dat_o), 64'h0000_0000_DEAD_BEEF);
         $display("vector %0d rst=%b cyc=%b ack=%b gnt=%b s_adr=%h m_ack=%b",
                  i, rst, m_cyc, s_ack, gnt_o, s_adr_o, m_ack_o);
         edge_step();
      end

      // Fairness: all masters request; each does one acked access then drops CYC once.
      do_reset();
      m_cyc = 4'hF;
      tick();
      for (int n = 0; n < 5; n++) begin
         int g;
         g = n % NUM_M;
         m_stb = onehot(g); s_ack = 1;
         settle();
         check("fair_gnt", 64'(gnt_o), 64'(onehot(g)));
         check("fair_ack", 64'(m_ack_o), 64'(onehot(g)));
         $display("fairness tenure %0d gnt=%b", n, gnt_o);
         edge_step();
         m_cyc = 4'hF & ~onehot(g); m_stb = '0; s_ack = 0;
         tick();
         m_cyc = 4'hF;
         settle();
         check("fair_dead", 64'(gnt_o), 64'h0);
         edge_step();
      end

      // No preemption: master 1 holds its tenure while master 0 waits.
      do_reset();
      m_cyc = 4'b0010;
      tick();
      m_cyc = 4'b0011;
      for (int n = 0; n < 10; n++) begin
         settle();
         check("nopre_hold", 64'(gnt_o), 64'h2);
         edge_step();
      end
      m_cyc = 4'b0001;
      settle();
      check("nopre_last", 64'(gnt_o), 64'h2);
      edge_step();
      settle();
      check("nopre_dead", 64'(gnt_o), 64'h0);
      edge_step();
      settle();
      check("nopre_next", 64'(gnt_o), 64'h1);
      $display("no-preemption handover gnt=%b", gnt_o);
      edge_step();

      // Reset in the middle of master 3's tenure; a stray ack must not be routed.
      do_reset();
      m_cyc = 4'b1000; m_stb = 4'b1000;
      tick();
      settle();
      check("rstmid_stb", 64'({gnt_o, s_stb_o}), 64'({4'b1000, 1'b1}));
      edge_step();
      rst = 0; s_ack = 1;
      tick();
      for (int n = 0; n < 3; n++) begin
         settle();
         check("rstmid_gnt", 64'(gnt_o), 64'h0);
         check("rstmid_slave", 64'({s_cyc_o, s_stb_o}), 64'h0);
         check("rstmid_ack", 64'(m_ack_o), 64'h0);
         $display("reset-mid cycle %0d gnt=%b s_cyc=%b m_ack=%b", n, gnt_o, s_cyc_o, m_ack_o);
         edge_step();
      end
      rst = 1;
      clear_inputs();
      tick();

      // Silent slave: watchdog ERR pulse when enabled, never otherwise.
      do_reset();
      m_cyc = 4'b0001; m_stb = 4'b0001;
      tick();
      for (int c = 0; c <= 20; c++) begin
         logic [NUM_M-1:0] eerr;
`ifdef WSHB_ARB_TIMEOUT_EN
         eerr = (c == TIMEOUT) ? 4'b0001 : 4'b0000;
`else
         eerr = 4'b0000;
`endif
         settle();
         check("timeout_err", 64'(m_err_o), 64'(eerr));
         edge_step();
      end
      $display("timeout sequence done");

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) != 0);
         for (int k = 0; k < NUM_M; k++) begin
            if ($urandom_range(0, 5) == 0) m_cyc[k] = ~m_cyc[k];
         end
         m_stb = 4'($urandom);
         m_we  = 4'($urandom);
         m_adr = {$urandom, $urandom, $urandom, $urandom};
         m_sel = 16'($urandom);
         m_dat = {$urandom, $urandom, $urandom, $urandom};
         s_dat_i = $urandom;
         s_ack = ($urandom_range(0, 3) == 0);
         s_err = ($urandom_range(0, 7) == 0);
         s_rty = ($urandom_range(0, 7) == 0);
         tick();
      end
      $display("random run done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
